// File: rtl/gate_tt_sequencer.sv
// Walks a 2-input gate through 00,01,10,11, holding each vector for DWELL cycles,
// captures the gate output per vector and grades the table against an expected mask.
module gate_tt_sequencer #(
    parameter int unsigned DWELL = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [1:0] err_idx
);

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       exp_q;
    logic [3:0]       table_next;
    logic [3:0]       mismatch;
    logic [1:0]       err_next;

    // Final table including the bit being captured this edge, so pass/err_idx
    // can be registered on the same edge that enters DONE.
    always_comb begin
        table_next         = result;
        table_next[idx_q]  = c;
        mismatch           = table_next ^ exp_q;
        err_next           = 2'd0;
        if (mismatch[0])      err_next = 2'd0;
        else if (mismatch[1]) err_next = 2'd1;
        else if (mismatch[2]) err_next = 2'd2;
        else if (mismatch[3]) err_next = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            exp_q   <= 4'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            result  <= 4'd0;
            err_idx <= 2'd0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    a    <= 1'b0;
                    b    <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        exp_q   <= expected;
                        pass    <= 1'b0;
                        result  <= 4'd0;
                        err_idx <= 2'd0;
                        idx_q   <= 2'd0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StDrive;
                    end
                end
                StDrive: begin
                    if (cnt_q == CntLast) begin
                        cnt_q         <= '0;
                        result[idx_q] <= c;
                        if (idx_q == 2'd3) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            a       <= 1'b0;
                            b       <= 1'b0;
                            pass    <= (table_next == exp_q);
                            err_idx <= err_next;
                        end else begin
                            idx_q  <= idx_q + 2'd1;
                            {a, b} <= idx_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: two instances (DWELL=10 and DWELL=1) driving a modelled gate,
// checked every cycle against a timing/truth-table model plus directed literal checks.
module tb_gate_tt_sequencer;

    localparam int D0 = 10;
    localparam int D1 = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s[2];
    logic [3:0] expected_s[2];
    logic [3:0] gtt[2];
    logic       a_o[2], b_o[2], c_s[2], busy_o[2], done_o[2], pass_o[2];
    logic [3:0] result_o[2];
    logic [1:0] err_o[2];

    always #5 clk = ~clk;

    assign c_s[0] = gtt[0][{a_o[0], b_o[0]}];
    assign c_s[1] = gtt[1][{a_o[1], b_o[1]}];

    gate_tt_sequencer #(.DWELL(D0), .CNT_W(8)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .expected(expected_s[0]),
        .a(a_o[0]), .b(b_o[0]), .c(c_s[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .result(result_o[0]), .err_idx(err_o[0])
    );

    gate_tt_sequencer #(.DWELL(D1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .expected(expected_s[1]),
        .a(a_o[1]), .b(b_o[1]), .c(c_s[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .result(result_o[1]), .err_idx(err_o[1])
    );

    int     checks = 0;
    int     errors = 0;
    longint n = 0;        // number of rising edges seen
    longint s[2];         // edge at which the current/last run was accepted
    bit     v[2];         // a run has been accepted since reset
    logic [3:0] exp_l[2], tt_l[2];

    function automatic int dw(int j);
        return (j == 0) ? D0 : D1;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Expected outputs for the cycle following edge n, from run timing alone:
    // k cycles after acceptance, vectors are k/D, bit i is captured after (i+1)*D.
    function automatic logic [10:0] model_out(int j);
        longint     k;
        int         d;
        logic [1:0] ab, err;
        logic       bsy, dn, ps;
        logic [3:0] res;
        d = dw(j);
        ab = 2'd0; bsy = 1'b0; dn = 1'b0; ps = 1'b0; res = 4'd0; err = 2'd0;
        if (v[j]) begin
            k = n - s[j];
            bsy = (k < 4 * d);
            if (bsy) ab = 2'(k / d);
            dn = (k == 4 * d);
            for (int i = 0; i < 4; i++)
                if (k >= (i + 1) * d) res[i] = tt_l[j][i];
            if (k >= 4 * d) begin
                ps = (tt_l[j] == exp_l[j]);
                for (int i = 3; i >= 0; i--)
                    if (tt_l[j][i] != exp_l[j][i]) err = 2'(i);
            end
        end
        return {ab, bsy, dn, ps, res, err};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            n++;
            for (int j = 0; j < 2; j++) begin
                if (!rst_n) v[j] = 1'b0;
                else if (start_s[j] && !(v[j] && (n - 1 - s[j] <= 4 * dw(j)))) begin
                    s[j] = n; v[j] = 1'b1; exp_l[j] = expected_s[j]; tt_l[j] = gtt[j];
                end
            end
            #1;
            for (int j = 0; j < 2; j++)
                check($sformatf("cycle%0d inst%0d outputs", n, j),
                      32'({a_o[j], b_o[j], busy_o[j], done_o[j], pass_o[j], result_o[j], err_o[j]}),
                      32'(model_out(j)));
        end
    end

    // One run: a clean IDLE cycle, a start pulse, then wait (bounded) for done.
    task automatic run(input int j, input logic [3:0] g, input logic [3:0] e, input bit disturb,
                       output longint t_start, output longint t_done);
        bit seen = 0;
        @(negedge clk);
        gtt[j] = g; expected_s[j] = e; start_s[j] = 1'b1;
        @(negedge clk);
        t_start = n; start_s[j] = 1'b0; t_done = 0;
        for (int i = 0; i < 4 * dw(j) + 10 && !seen; i++) begin
            if (disturb) begin
                start_s[j] = 1'($urandom % 2);
                expected_s[j] = ($urandom % 2) ? 4'b1111 : ~e;
            end
            @(negedge clk);
            if (done_o[j]) begin seen = 1; t_done = n; end
        end
        start_s[j] = 1'b0; expected_s[j] = e;
        check($sformatf("inst%0d done seen", j), 32'(seen), 32'd1);
    endtask

    initial begin
        longint ts, td;
        int     dcnt;
        bit     seen;
        logic [3:0] g, e;
        int     j;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; expected_s[i] = 4'd0; gtt[i] = 4'd0;
        end
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], result_o[0],
              err_o[0]}), 32'd0);
        rst_n = 1'b1;

        // XOR, DWELL=10
        run(0, 4'b0110, 4'b0110, 0, ts, td);
        check("xor done latency", 32'(td - ts), 32'd40);
        check("xor result", 32'(result_o[0]), 32'h6);
        check("xor pass", 32'(pass_o[0]), 32'd1);
        check("xor err_idx", 32'(err_o[0]), 32'd0);

        // AND gate against XOR mask, outputs held afterwards
        run(0, 4'b1000, 4'b0110, 0, ts, td);
        check("and result", 32'(result_o[0]), 32'h8);
        check("and pass", 32'(pass_o[0]), 32'd0);
        check("and err_idx", 32'(err_o[0]), 32'd1);
        repeat (20) @(negedge clk);
        check("and held", 32'({busy_o[0], done_o[0], pass_o[0], result_o[0], err_o[0]}),
              32'({1'b0, 1'b0, 1'b0, 4'h8, 2'd1}));

        // DWELL=1, then start held high
        run(1, 4'b0110, 4'b0110, 0, ts, td);
        check("dwell1 done latency", 32'(td - ts), 32'd4);
        check("dwell1 pass", 32'(pass_o[1]), 32'd1);
        @(negedge clk);
        start_s[1] = 1'b1; dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o[1]) dcnt++;
            check("busy/done overlap", 32'(busy_o[1] & done_o[1]), 32'd0);
        end
        start_s[1] = 1'b0;
        check("back-to-back done count", 32'(dcnt), 32'd3);
        repeat (10) @(negedge clk);

        // start and expected disturbed mid-run
        run(0, 4'b0110, 4'b0110, 1, ts, td);
        check("disturb latency", 32'(td - ts), 32'd40);
        check("disturb pass", 32'(pass_o[0]), 32'd1);
        check("disturb result", 32'(result_o[0]), 32'h6);

        // asynchronous reset during the {a,b}=10 dwell
        @(negedge clk);
        gtt[0] = 4'b0110; expected_s[0] = 4'b0110; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (a_o[0] && !b_o[0]) seen = 1;
        end
        check("reached vector 10", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("pre-reset partial result", 32'(result_o[0]), 32'h2);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", 32'({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0],
               result_o[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (30) begin @(negedge clk); if (done_o[0]) dcnt++; end
        check("no done after reset", 32'(dcnt), 32'd0);
        run(0, 4'b0110, 4'b0110, 0, ts, td);
        check("post-reset latency", 32'(td - ts), 32'd40);
        check("post-reset pass", 32'(pass_o[0]), 32'd1);

        // c stuck at 1
        run(0, 4'b1111, 4'b0110, 0, ts, td);
        check("stuck result", 32'(result_o[0]), 32'hf);
        check("stuck pass", 32'(pass_o[0]), 32'd0);
        check("stuck err_idx", 32'(err_o[0]), 32'd0);

        // randomized runs, checked by the per-cycle model
        for (int r = 0; r < 40; r++) begin
            j = int'($urandom % 2);
            g = 4'($urandom);
            e = ($urandom % 2) ? g : 4'($urandom);
            run(j, g, e, bit'($urandom % 2), ts, td);
            check("random latency", 32'(td - ts), 32'(4 * dw(j)));
            repeat ($urandom % 4) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
